bpsk_tx_scheduler: RTL
======================

// Module: bpsk_tx_scheduler
// PURPOSE
//   Sequences the BPSK modulator from the UART-style receiver output. Each good
//   word from the receiver (done pulse + 9-bit data/parity) is queued in a
//   small FIFO. Queued words are then replayed one at a time: the word is held
//   on mod_data while mod_en is asserted for a fixed symbol window. Words with
//   a parity error, or words that arrive while the FIFO is full, are dropped and
//   counted. The block sits between receiver and bpsk_modulator in the top level.
// PARAMETERS
//   ADDR_WIDTH     8   payload bits per word; the word is ADDR_WIDTH+1 bits wide (data + parity)
//   FIFO_DEPTH     4   queue entries; power of 2, >= 2
//   SYMBOL_CYCLES  16  clk cycles mod_en stays high per word; >= 1
//   GAP_CYCLES     2   idle clk cycles between words; 0 allowed (GAP state skipped)
// PORTS
//   clk         in   1             system clock, rising edge
//   arst        in   1             asynchronous reset, active-high
//   rx_done     in   1             one-cycle pulse: rx_data and rx_err are valid this cycle
//   rx_data     in   ADDR_WIDTH+1  received word, parity bit included
//   rx_err      in   1             parity error flag for rx_data (from the decoder)
//   clr         in   1             synchronous pulse: clears err_cnt and ovf
//   mod_en      out  1             enable to the bpsk_modulator
//   mod_data    out  ADDR_WIDTH+1  word currently being transmitted
//   busy        out  1             high when state != IDLE or the FIFO is not empty
//   fifo_level  out  clog2(DEPTH)+1  number of occupied FIFO entries
//   err_cnt     out  8             count of parity-error drops; saturates at 255
//   ovf         out  1             sticky: a good word was dropped because the FIFO was full
// BEHAVIOUR
//   Reset: all outputs are 0, the FIFO is empty and state = IDLE. arst takes
//     effect immediately in any state; mod_en falls without waiting for a clock edge.
//   Push (on a rising edge where rx_done = 1):
//     - rx_err = 1: drop the word; err_cnt increments unless it is already 255.
//     - rx_err = 0, FIFO not full, or full with a pop on the same edge: push the word.
//     - rx_err = 0, FIFO full and no pop on that edge: drop the word; ovf is set to 1.
//   clr takes priority over a same-cycle increment or set: after clr, err_cnt = 0 and ovf = 0.
//   FSM (all outputs registered):
//     IDLE -> LOAD   when fifo_level != 0.
//     LOAD  (1 cycle): pop the head word into mod_data; mod_en = 0; then -> SEND.
//     SEND  mod_en = 1 for exactly SYMBOL_CYCLES cycles; mod_data stays stable.
//           Next state is GAP, or IDLE when GAP_CYCLES = 0.
//     GAP   mod_en = 0 for exactly GAP_CYCLES cycles; then -> IDLE.
//   Latency: if rx_done is high in cycle 0 with the FIFO empty and state = IDLE:
//     - fifo_level = 1 in cycle 1;
//     - LOAD in cycle 2;
//     - mod_data valid from cycle 3;
//     - mod_en high in cycles 3 .. 3+SYMBOL_CYCLES-1.
//   Back-to-back words: for each further queued word, mod_en rises again
//     GAP_CYCLES+2 cycles after it falls (GAP + IDLE + LOAD).
//   mod_data holds the last sent word after SEND ends; it does not clear.
//   FIFO pointers are log2(DEPTH) bits wide and wrap; a separate count gives full/empty.
//   A push during SEND or GAP only queues the word; the current transmission is not disturbed.
// TESTING
//   1. Reset, then one rx_done with data=9'h1A5 and err=0 -> mod_data=9'h1A5 from cycle 3;
//      mod_en high for exactly 16 cycles; busy falls after the gap.
//   2. Three good words in consecutive cycles -> sent in order; each mod_en window is 16 cycles;
//      mod_en is low for 4 cycles between windows; fifo_level peaks at 3 (or 2 if a pop overlaps).
//   3. rx_done with err=1, repeated 300 times -> nothing is sent; fifo_level stays 0;
//      err_cnt saturates at 255; one clr pulse -> err_cnt = 0.
//   4. Six good words in back-to-back cycles while IDLE -> exactly 5 are sent (4 stored plus
//      one freed by the first pop); ovf = 1 and stays set until clr.
//   5. arst asserted mid-SEND (cycle 8 of 16) -> mod_en is 0 asynchronously; FIFO empty;
//      after release, a new word starts a full 16-cycle window.
//   6. rx_done on the same edge as a LOAD pop with the FIFO full -> the word is accepted and
//      ovf stays 0.

Source files
------------

// File: rtl/bpsk_tx_scheduler.sv
// BPSK transmit scheduler: queues good receiver words in a small FIFO and
// replays them one at a time to the modulator, holding each word on mod_data
// while mod_en is high for a fixed symbol window followed by an idle gap.
// Parity-error words and words arriving on a full FIFO are dropped and counted.
module bpsk_tx_scheduler #(
  parameter int ADDR_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int SYMBOL_CYCLES = 16,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          rx_done,
  input  logic [ADDR_WIDTH:0]           rx_data,
  input  logic                          rx_err,
  input  logic                          clr,
  output logic                          mod_en,
  output logic [ADDR_WIDTH:0]           mod_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    err_cnt,
  output logic                          ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  // Wide enough for the longer of the symbol and gap windows.
  localparam int CW = $clog2(SYMBOL_CYCLES + GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic [ADDR_WIDTH:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]         count_reg;
  logic                  mod_en_reg;
  logic [ADDR_WIDTH:0]   mod_data_reg;
  logic [7:0]            err_cnt_reg;
  logic                  ovf_reg;
  logic                  pop, push, full;

  // The only pop happens in LOAD, which is entered only with a non-empty FIFO.
  assign pop  = (state_reg == LOAD);
  assign full = (count_reg == LW'(FIFO_DEPTH));
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push = rx_done && !rx_err && (!full || pop);

  // State and window-counter register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: LOAD is a single cycle, SEND and GAP are counted windows.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) state_next = LOAD;
      end
      LOAD: begin
        state_next = SEND;
        cnt_next   = '0;
      end
      SEND: begin
        if (int'(cnt_reg) == SYMBOL_CYCLES - 1) begin
          cnt_next = '0;
          if (GAP_CYCLES == 0) state_next = IDLE;
          else                 state_next = GAP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      GAP: begin
        if (int'(cnt_reg) == GAP_CYCLES - 1) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // FIFO storage; a read on the same edge as a write to the same slot returns the old word.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= rx_data;
  end

  // FIFO pointers/occupancy and the registered modulator outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      mod_en_reg   <= 1'b0;
      mod_data_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + PW'(1);
        mod_data_reg <= mem[rd_ptr_reg];
      end
      count_reg  <= count_reg + LW'(push) - LW'(pop);
      mod_en_reg <= (state_next == SEND);
    end
  end

  // Drop statistics; clr wins over a same-cycle increment or set.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      err_cnt_reg <= '0;
      ovf_reg     <= 1'b0;
    end else if (clr) begin
      err_cnt_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      if (rx_done && rx_err && (err_cnt_reg != 8'hFF)) err_cnt_reg <= err_cnt_reg + 8'd1;
      if (rx_done && !rx_err && full && !pop) ovf_reg <= 1'b1;
    end
  end

  assign mod_en     = mod_en_reg;
  assign mod_data   = mod_data_reg;
  assign busy       = (state_reg != IDLE) || (count_reg != '0);
  assign fifo_level = count_reg;
  assign err_cnt    = err_cnt_reg;
  assign ovf        = ovf_reg;

endmodule
